// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared widths, arbitration limits and the writeback request type
//   XLEN       register data width
//   NREG       architectural register count, REG_IDX_W its index width
//   MAX_WAIT   contention cycles an ALU request may lose before it is forced through
//   wb_req_t   {valid, rdsel, data} writeback request / registered write-port image
package rv32i_pkg;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int REG_IDX_W = $clog2(NREG);
   localparam int MAX_WAIT = 4;
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef struct packed {
      logic valid;
      reg_idx_t rdsel;
      logic [XLEN-1:0] data;
   } wb_req_t;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register outstanding-write bits with two combinational read ports
//   clk, reset          clock, synchronous active-high reset (clears every bit)
//   set_en, set_idx     issue of a register-writing instruction
//   clr_en, clr_idx     writeback grant for a register
//   rs1sel, rs2sel      hazard query indices
//   rs1_busy, rs2_busy  queried register has an outstanding write (x0 never busy)
module wb_scoreboard
   import rv32i_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 set_en,
   input  logic [REG_IDX_W-1:0] set_idx,
   input  logic                 clr_en,
   input  logic [REG_IDX_W-1:0] clr_idx,
   input  logic [REG_IDX_W-1:0] rs1sel,
   input  logic [REG_IDX_W-1:0] rs2sel,
   output logic                 rs1_busy,
   output logic                 rs2_busy
);
   logic [NREG-1:0] busy, set_mask, clr_mask;
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      set_mask[set_idx] = set_en;
      clr_mask[clr_idx] = clr_en;
   end
   // set is applied after clear so a same-cycle reissue keeps the newer producer outstanding;
   // bit 0 is masked so x0 can never become busy
   always_ff @(posedge clk)
      busy <= reset ? '0 : ((busy & ~clr_mask) | set_mask) & ~NREG'(1);
   assign rs1_busy = busy[rs1sel];
   assign rs2_busy = busy[rs2sel];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU/load writebacks onto the single regfile write port
//   clk, reset                               clock, synchronous active-high reset
//   alu_valid/alu_rdsel/alu_data, alu_ready  ALU writeback request and acceptance
//   mem_valid/mem_rdsel/mem_data, mem_ready  load writeback request and acceptance
//   issue_valid, issue_rdsel                 decode marks a destination outstanding
//   rs1sel/rs2sel, rs1_busy/rs2_busy         RAW hazard query against the scoreboard
//   enrd, rdsel, rd                          registered regfile write port
module regfile_wb_arbiter
   import rv32i_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 alu_valid,
   output logic                 alu_ready,
   input  logic [REG_IDX_W-1:0] alu_rdsel,
   input  logic [XLEN-1:0]      alu_data,
   input  logic                 mem_valid,
   output logic                 mem_ready,
   input  logic [REG_IDX_W-1:0] mem_rdsel,
   input  logic [XLEN-1:0]      mem_data,
   input  logic                 issue_valid,
   input  logic [REG_IDX_W-1:0] issue_rdsel,
   input  logic [REG_IDX_W-1:0] rs1sel,
   input  logic [REG_IDX_W-1:0] rs2sel,
   output logic                 rs1_busy,
   output logic                 rs2_busy,
   output logic                 enrd,
   output logic [REG_IDX_W-1:0] rdsel,
   output logic [XLEN-1:0]      rd
);
   logic [WAIT_W-1:0] wait_cnt;
   logic alu_nz, mem_nz, starve, alu_grant, mem_grant;
   wb_req_t wb_d, wb_q;
   // x0 requests never compete for the port, they are simply acknowledged
   always_comb begin
      alu_nz = alu_valid && alu_rdsel != '0;
      mem_nz = mem_valid && mem_rdsel != '0;
      starve = wait_cnt == WAIT_W'(MAX_WAIT);
      alu_grant = alu_nz && (!mem_nz || starve);
      mem_grant = mem_nz && !alu_grant;
      alu_ready = !reset && alu_valid && (alu_rdsel == '0 || alu_grant);
      mem_ready = !reset && mem_valid && (mem_rdsel == '0 || mem_grant);
      wb_d = alu_grant ? wb_req_t'{valid: 1'b1, rdsel: alu_rdsel, data: alu_data}
           : mem_grant ? wb_req_t'{valid: 1'b1, rdsel: mem_rdsel, data: mem_data}
           : wb_req_t'{valid: 1'b0, rdsel: wb_q.rdsel, data: wb_q.data};
   end
   always_ff @(posedge clk) begin
      wb_q <= reset ? '0 : wb_d;
      if (reset || !alu_nz || alu_grant)
         wait_cnt <= '0;
      else if (!starve)
         wait_cnt <= wait_cnt + WAIT_W'(1);
   end
   assign enrd = wb_q.valid;
   assign rdsel = wb_q.rdsel;
   assign rd = wb_q.data;
   wb_scoreboard u_sb (
      .clk      (clk),
      .reset    (reset),
      .set_en   (issue_valid),
      .set_idx  (issue_rdsel),
      .clr_en   (wb_d.valid),
      .clr_idx  (wb_d.rdsel),
      .rs1sel   (rs1sel),
      .rs2sel   (rs2sel),
      .rs1_busy (rs1_busy),
      .rs2_busy (rs2_busy)
   );
endmodule
